// File: rtl/shift_clock_pkg.sv
// Shared types and constants for the backscatter shift-clock arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package shift_clock_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int LEN_W_DEF = 16;

    localparam int REQ_0 = 0;
    localparam int REQ_1 = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_clock_div.sv
// Programmable divider: each half period of clock_out lasts hp+1 enabled clocks.
// Latency: first rising toggle hp+1 clocks after counting starts; fall strobe is combinational.
// Backpressure: none; clr has priority over en and forces clock_out low.
module shift_clock_div #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] hp,
    output logic             clock_out,
    output logic             fall
);

    logic [CNT_W-1:0] cnt;
    logic             q;
    logic             hit;

    assign hit       = (cnt == hp);
    assign fall      = en && !clr && hit && q;
    assign clock_out = q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt <= '0;
            q   <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            q   <= 1'b0;
        end else if (en) begin
            if (hit) begin
                cnt <= '0;
                q   <= ~q;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/shift_clock_ctrl.sv
// Round-robin arbiter and FSM sharing one shift-clock divider between two requesters.
// Latency: grant one clock after req seen in IDLE; busy for 2N(hp+1)+1 clocks.
// Backpressure: req is a level held until done; dropping it mid-run aborts without done.
module shift_clock_ctrl
    import shift_clock_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [CNT_W-1:0] half_period_0,
    input  logic [CNT_W-1:0] half_period_1,
    input  logic [LEN_W-1:0] n_periods_0,
    input  logic [LEN_W-1:0] n_periods_1,
    output logic [1:0]       grant,
    output logic             busy,
    output logic [1:0]       done,
    output logic             clock_out
);

    state_t           state, state_d;
    logic             owner, owner_d;
    logic             last, last_d;
    logic [CNT_W-1:0] hp, hp_d;
    logic [LEN_W-1:0] rem, rem_d;
    logic             win;
    logic             div_en;
    logic             div_clr;
    logic             div_fall;
    logic [1:0]       owner_oh;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
            hp    <= '0;
            rem   <= '0;
        end else begin
            state <= state_d;
            owner <= owner_d;
            last  <= last_d;
            hp    <= hp_d;
            rem   <= rem_d;
        end
    end

    always_comb begin
        state_d = state;
        owner_d = owner;
        last_d  = last;
        hp_d    = hp;
        rem_d   = rem;
        win     = 1'b0;
        div_en  = 1'b0;
        div_clr = 1'b1;
        case (state)
            IDLE: begin
                if (|req) begin
                    // Under contention the requester that did not win last time goes first.
                    win     = (req == 2'b11) ? ~last : req[REQ_1];
                    owner_d = win;
                    last_d  = win;
                    hp_d    = win ? half_period_1 : half_period_0;
                    rem_d   = win ? n_periods_1 : n_periods_0;
                    state_d = (rem_d == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (!req[owner]) begin
                    state_d = IDLE;
                end else begin
                    div_en  = 1'b1;
                    div_clr = 1'b0;
                    if (div_fall && rem != '0) begin
                        rem_d = rem - LEN_W'(1);
                        if (rem == LEN_W'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    shift_clock_div #(
        .CNT_W (CNT_W)
    ) u_div (
        .clock     (clock),
        .reset     (reset),
        .en        (div_en),
        .clr       (div_clr),
        .hp        (hp),
        .clock_out (clock_out),
        .fall      (div_fall)
    );

    assign owner_oh = owner ? 2'b10 : 2'b01;
    assign busy     = (state != IDLE);
    assign grant    = busy ? owner_oh : 2'b00;
    assign done     = (state == DONE) ? owner_oh : 2'b00;

endmodule

// File: tb/tb_shift_clock_ctrl.sv
// Scoreboard bench for shift_clock_ctrl: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_shift_clock_ctrl;

    logic        clock;
    logic        reset;
    logic [1:0]  req;
    logic [7:0]  half_period_0, half_period_1;
    logic [15:0] n_periods_0, n_periods_1;
    logic [1:0]  grant;
    logic        busy;
    logic [1:0]  done;
    logic        clock_out;

    typedef struct packed {
        logic [1:0]  g;
        logic        b;
        logic [1:0]  d;
        logic        c;
        logic [7:0]  sc;
        logic [15:0] k;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;
    int   sc;

    shift_clock_ctrl #(.CNT_W(8), .LEN_W(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .req           (req),
        .half_period_0 (half_period_0),
        .half_period_1 (half_period_1),
        .n_periods_0   (n_periods_0),
        .n_periods_1   (n_periods_1),
        .grant         (grant),
        .busy          (busy),
        .done          (done),
        .clock_out     (clock_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Advance one edge and queue what the outputs must show after it.
    task automatic step(input logic [1:0] g, input logic b, input logic [1:0] d,
                        input logic c, input int k);
        exp_t e;
        @(posedge clock);
        #1;
        e.g  = g;
        e.b  = b;
        e.d  = d;
        e.c  = c;
        e.sc = 8'(sc);
        e.k  = 16'(k);
        exp_q.push_back(e);
    endtask

    task automatic idle_step();
        step(2'b00, 1'b0, 2'b00, 1'b0, 16'hffff);
    endtask

    // Cycles k0..k1 of a transfer granted at k=0: clock_out high in odd half periods,
    // done on k = 2N(hp+1). Optionally drop all requests during the last cycle.
    task automatic xfer(input int own, input int hp, input int n,
                        input int k0, input int k1, input bit drop);
        logic [1:0] oh;
        int         kdone;
        logic       c;
        oh    = (own == 1) ? 2'b10 : 2'b01;
        kdone = 2 * n * (hp + 1);
        for (int k = k0; k <= k1; k++) begin
            c = (((k / (hp + 1)) % 2) == 1) && (k != kdone);
            step(oh, 1'b1, (k == kdone) ? oh : 2'b00, c, k);
            if (drop && k == k1) req = 2'b00;
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (grant !== e.g || busy !== e.b || done !== e.d || clock_out !== e.c) begin
                n_bad++;
                $display("FAIL outputs sc=%0d k=%0d: got grant=%b busy=%b done=%b clk=%b, required grant=%b busy=%b done=%b clk=%b",
                         e.sc, e.k, grant, busy, done, clock_out, e.g, e.b, e.d, e.c);
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        sc    = 0;
        reset = 1'b0;
        req   = 2'b00;
        half_period_0 = 8'd0;
        half_period_1 = 8'd0;
        n_periods_0   = 16'd0;
        n_periods_1   = 16'd0;

        // Reset state
        idle_step();
        idle_step();
        reset = 1'b1;
        idle_step();

        // Single request hp=1 N=3: rises 2,6,10, falls 4,8,12, done at 12
        sc = 1;
        req = 2'b01; half_period_0 = 8'd1; n_periods_0 = 16'd3;
        xfer(0, 1, 3, 0, 12, 1'b1);
        idle_step();
        idle_step();

        // Contention from reset: 0, then 1, then 0 again
        sc = 2;
        reset = 1'b0;
        idle_step();
        reset = 1'b1;
        req = 2'b11;
        half_period_0 = 8'd0; n_periods_0 = 16'd2;
        half_period_1 = 8'd2; n_periods_1 = 16'd1;
        xfer(0, 0, 2, 0, 4, 1'b0);
        idle_step();
        xfer(1, 2, 1, 0, 6, 1'b0);
        idle_step();
        xfer(0, 0, 2, 0, 4, 1'b1);
        idle_step();

        // Zero length on requester 1
        sc = 3;
        req = 2'b10; half_period_1 = 8'd5; n_periods_1 = 16'd0;
        xfer(1, 5, 0, 0, 0, 1'b1);
        idle_step();

        // Abort mid-high phase; latched hp survives input changes; pending req[1] follows
        sc = 4;
        req = 2'b01; half_period_0 = 8'd3; n_periods_0 = 16'd5;
        xfer(0, 3, 5, 0, 0, 1'b0);
        req = 2'b11; half_period_0 = 8'd7; n_periods_0 = 16'd1;
        half_period_1 = 8'd0; n_periods_1 = 16'd1;
        xfer(0, 3, 5, 1, 5, 1'b0);
        req = 2'b10;
        idle_step();
        // hp=0, N=1: high exactly one cycle, then low with done
        xfer(1, 0, 1, 0, 2, 1'b1);
        idle_step();

        // hp=255, N=1: high for 256 cycles
        sc = 5;
        req = 2'b01; half_period_0 = 8'd255; n_periods_0 = 16'd1;
        xfer(0, 255, 1, 0, 512, 1'b1);
        idle_step();

        // Reset during RUN: outputs clear, no done, pointer back to requester 0 first
        sc = 6;
        req = 2'b10; half_period_1 = 8'd1; n_periods_1 = 16'd4;
        xfer(1, 1, 4, 0, 5, 1'b0);
        reset = 1'b0;
        idle_step();
        reset = 1'b1;
        req = 2'b11; half_period_0 = 8'd0; n_periods_0 = 16'd1;
        xfer(0, 0, 1, 0, 2, 1'b1);
        idle_step();

        @(negedge clock);
        @(negedge clock);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
